// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 8x8 register file.
//   DATA_W   : register width
//   ADDR_W   : register address width, NUM_REGS = 2**ADDR_W
//   RD_DLY   : read-path delay (time units). Reference value for benches only;
//              the synthesizable read path is purely combinational.
//   WR_DLY   : write-commit delay after CLK posedge (reference value only)
//   RST_DLY  : register-clear delay after RESET rises (reference value only)
//   wr_state_e : write FSM states (WS_IDLE, WS_HOLD)
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 1 << ADDR_W;
   localparam int RD_DLY   = 2;
   localparam int WR_DLY   = 1;
   localparam int RST_DLY  = 2;

   typedef enum logic {
      WS_IDLE = 1'b0,
      WS_HOLD = 1'b1
   } wr_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One asynchronous read port of the register file: selects regs_i[addr_i] and,
// when fwd_en_i is set and the forward address matches, substitutes the
// in-flight write data (write-through forwarding).
// Ports:
//   regs_i      in   NUM_REGS x DATA_W  committed register contents
//   addr_i      in   ADDR_W             read select
//   fwd_en_i    in   1                  forwarding candidate valid
//   fwd_addr_i  in   ADDR_W             address of the forwarding candidate
//   fwd_data_i  in   DATA_W             data of the forwarding candidate
//   data_o      out  DATA_W             read data
// -----------------------------------------------------------------------------
module regfile_read_port
   import regfile_pkg::*;
(
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
   input  logic [ADDR_W-1:0]               addr_i,
   input  logic                            fwd_en_i,
   input  logic [ADDR_W-1:0]               fwd_addr_i,
   input  logic [DATA_W-1:0]               fwd_data_i,
   output logic [DATA_W-1:0]               data_o
);

   always_comb begin
      data_o = regs_i[addr_i];
      if (fwd_en_i && (fwd_addr_i == addr_i)) begin
         data_o = fwd_data_i;
      end
   end

endmodule

// File: rtl/reg_file_8x8.sv
// -----------------------------------------------------------------------------
// reg_file_8x8
// 8-entry x 8-bit register file with two asynchronous read ports and one
// stall-aware synchronous write port. A write that arrives while BUSYWAIT is
// high is captured into hold registers and committed on the first posedge
// where BUSYWAIT is low.
// Optional feature: define REGFILE_BYPASS_EN to forward an unstalled write
// (WRITE=1, BUSYWAIT=0) to any read port addressing the same register before
// the commit edge. Writes parked in the hold registers are never forwarded.
// Ports:
//   CLK          in   1       clock, posedge active
//   RESET        in   1       asynchronous active-high reset, clears all state
//   IN           in   DATA_W  write data
//   INADDRESS    in   ADDR_W  write register select
//   WRITE        in   1       write enable
//   BUSYWAIT     in   1       memory stall, blocks write commit
//   OUT1ADDRESS  in   ADDR_W  read port 1 select
//   OUT2ADDRESS  in   ADDR_W  read port 2 select
//   OUT1         out  DATA_W  read port 1 data
//   OUT2         out  DATA_W  read port 2 data
//   WR_PENDING   out  1       a write is parked waiting for BUSYWAIT to drop
// -----------------------------------------------------------------------------
module reg_file_8x8
   import regfile_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              WRITE,
   input  logic              BUSYWAIT,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   output logic [DATA_W-1:0] OUT1,
   output logic [DATA_W-1:0] OUT2,
   output logic              WR_PENDING
);

   // Storage and write FSM state
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
   wr_state_e                       state_q, state_d;
   logic [ADDR_W-1:0]               hold_addr_q, hold_addr_d;
   logic [DATA_W-1:0]               hold_data_q, hold_data_d;

   // Commit request produced by the FSM for this edge
   logic                            commit_en;
   logic [ADDR_W-1:0]               commit_addr;
   logic [DATA_W-1:0]               commit_data;
   logic [NUM_REGS-1:0]             wr_sel;

   // Forwarding candidate presented to both read ports
   logic                            fwd_en;

   // -------------------------------------------------------------------------
   // Write FSM: next state and commit decode. An X on WRITE or BUSYWAIT falls
   // through the if-conditions, so it produces neither a commit nor a state
   // change.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      commit_en   = 1'b0;
      commit_addr = INADDRESS;
      commit_data = IN;

      case (state_q)
         WS_IDLE: begin
            if (WRITE) begin
               if (BUSYWAIT) begin
                  hold_addr_d = INADDRESS;
                  hold_data_d = IN;
                  state_d     = WS_HOLD;
               end else if (!BUSYWAIT) begin
                  commit_en = 1'b1;
               end
            end
         end
         WS_HOLD: begin
            // New requests are ignored while a write is parked, including on
            // the release edge itself.
            if (!BUSYWAIT) begin
               commit_en   = 1'b1;
               commit_addr = hold_addr_q;
               commit_data = hold_data_q;
               state_d     = WS_IDLE;
            end
         end
         default: begin
            state_d = WS_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= WS_IDLE;
         hold_addr_q <= '0;
         hold_data_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
      end
   end

   // -------------------------------------------------------------------------
   // Register array: one-hot write select per entry
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
         assign wr_sel[gi] = commit_en && (commit_addr == ADDR_W'(gi));
      end
   endgenerate

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         regs_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               regs_q[i] <= commit_data;
            end
         end
      end
   end

   assign WR_PENDING = (state_q == WS_HOLD);

   // -------------------------------------------------------------------------
   // Forwarding: only a write that will commit directly from IDLE on the
   // coming edge is visible early; nothing is forwarded during reset.
   // -------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
   assign fwd_en = WRITE && !BUSYWAIT && (state_q == WS_IDLE) && !RESET;
`else
   assign fwd_en = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Read ports
   // -------------------------------------------------------------------------
   regfile_read_port u_rd1 (
      .regs_i     (regs_q),
      .addr_i     (OUT1ADDRESS),
      .fwd_en_i   (fwd_en),
      .fwd_addr_i (INADDRESS),
      .fwd_data_i (IN),
      .data_o     (OUT1)
   );

   regfile_read_port u_rd2 (
      .regs_i     (regs_q),
      .addr_i     (OUT2ADDRESS),
      .fwd_en_i   (fwd_en),
      .fwd_addr_i (INADDRESS),
      .fwd_data_i (IN),
      .data_o     (OUT2)
   );

endmodule

// File: tb/tb_reg_file_8x8.sv
// -----------------------------------------------------------------------------
// tb_reg_file_8x8
// Directed and randomized stimulus for reg_file_8x8. The stimulus process
// pushes the expected OUT1/OUT2/WR_PENDING into a queue and signals a sample
// event; a separate monitor pops the queue and compares against the DUT.
// Expected values come from a behavioural model (array + pending-write flag)
// or from constants in the directed sections.
// -----------------------------------------------------------------------------
module tb_reg_file_8x8;
   import regfile_pkg::*;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [7:0] IN = '0;
   logic [2:0] INADDRESS = '0;
   logic       WRITE = 1'b0;
   logic       BUSYWAIT = 1'b0;
   logic [2:0] OUT1ADDRESS = '0;
   logic [2:0] OUT2ADDRESS = '0;
   logic [7:0] OUT1;
   logic [7:0] OUT2;
   logic       WR_PENDING;

   reg_file_8x8 dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .IN          (IN),
      .INADDRESS   (INADDRESS),
      .WRITE       (WRITE),
      .BUSYWAIT    (BUSYWAIT),
      .OUT1ADDRESS (OUT1ADDRESS),
      .OUT2ADDRESS (OUT2ADDRESS),
      .OUT1        (OUT1),
      .OUT2        (OUT2),
      .WR_PENDING  (WR_PENDING)
   );

   always #5 CLK = ~CLK;

   // Scoreboard
   typedef struct {
      string      name;
      logic [7:0] o1;
      logic [7:0] o2;
      logic       pend;
   } exp_t;

   exp_t q[$];
   event sample_ev;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   // Behavioural model
   logic [7:0] mem [8];
   bit         m_pend;
   logic [2:0] m_haddr;
   logic [7:0] m_hdata;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      m_pend = 1'b0;
   endtask

   // What a read port should show right now, before the next edge.
   function automatic logic [7:0] exp_read(input logic [2:0] a);
      if (BYPASS && !RESET && !m_pend && WRITE && !BUSYWAIT && (a == INADDRESS))
         return IN;
      return mem[a];
   endfunction

   // State change at a posedge, using the inputs held across that edge.
   task automatic model_edge();
      if (RESET) begin
         model_clear();
      end else if (m_pend) begin
         if (!BUSYWAIT) begin
            mem[m_haddr] = m_hdata;
            m_pend = 1'b0;
         end
      end else if (WRITE) begin
         if (BUSYWAIT) begin
            m_pend  = 1'b1;
            m_haddr = INADDRESS;
            m_hdata = IN;
         end else begin
            mem[INADDRESS] = IN;
         end
      end
   endtask

   task automatic push_exp(input string nm, input logic [7:0] o1,
                           input logic [7:0] o2, input logic p);
      exp_t e;
      e.name = nm;
      e.o1   = o1;
      e.o2   = o2;
      e.pend = p;
      q.push_back(e);
      -> sample_ev;
      #1;
   endtask

   task automatic check_now(input string nm);
      #(RD_DLY);
      push_exp(nm, exp_read(OUT1ADDRESS), exp_read(OUT2ADDRESS), m_pend);
   endtask

   task automatic check_const(input string nm, input logic [7:0] o1,
                              input logic [7:0] o2, input logic p);
      #(RD_DLY);
      push_exp(nm, o1, o2, p);
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
   endtask

   task automatic drive(input logic w, input logic bw, input logic [2:0] wa,
                        input logic [7:0] d, input logic [2:0] a1,
                        input logic [2:0] a2);
      WRITE       = w;
      BUSYWAIT    = bw;
      INADDRESS   = wa;
      IN          = d;
      OUT1ADDRESS = a1;
      OUT2ADDRESS = a2;
   endtask

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
      total_cnt++;
      if (act !== req)
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      else
         pass_cnt++;
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         while (q.size() > 0) begin
            e = q.pop_front();
            cmp({e.name, ".out1"}, OUT1, e.o1);
            cmp({e.name, ".out2"}, OUT2, e.o2);
            cmp({e.name, ".wr_pending"}, {7'd0, WR_PENDING}, {7'd0, e.pend});
            $display("txn %-14s a1=%0d a2=%0d out1=%h out2=%h pend=%b", e.name,
                     OUT1ADDRESS, OUT2ADDRESS, OUT1, OUT2, WR_PENDING);
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      model_clear();
      #1;
      // Power-on reset
      RESET = 1'b1;
      model_clear();
      check_const("por", 8'h00, 8'h00, 1'b0);
      @(negedge CLK);
      step();
      RESET = 1'b0;

      // Preload every register with 8'hFF, then reset asynchronously
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 3'(i), 8'hFF, 3'(i), 3'(i));
         step();
      end
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd1);
      check_const("preload", 8'hFF, 8'hFF, 1'b0);
      RESET = 1'b1;
      model_clear();
      for (int i = 0; i < 8; i += 2) begin
         OUT1ADDRESS = 3'(i);
         OUT2ADDRESS = 3'(i + 1);
         check_const("rst_clear", 8'h00, 8'h00, 1'b0);
      end
      step();
      RESET = 1'b0;

      // Unstalled write: reg3 = A5
      drive(1'b1, 1'b0, 3'd3, 8'hA5, 3'd0, 3'd1);
      step();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
      check_const("wr_direct", 8'hA5, 8'hA5, 1'b0);

      // Stalled write to reg5, IN changes while held
      drive(1'b1, 1'b1, 3'd5, 8'h3C, 3'd5, 3'd5);
      step();
      IN = 8'h00;
      for (int i = 0; i < 2; i++) begin
         check_const("held", 8'h00, 8'h00, 1'b1);
         step();
      end
      check_const("held", 8'h00, 8'h00, 1'b1);
      WRITE    = 1'b0;
      BUSYWAIT = 1'b0;
      step();
      check_const("released", 8'h3C, 8'h3C, 1'b0);

      // Both ports on the same register
      drive(1'b1, 1'b0, 3'd2, 8'h81, 3'd0, 3'd0);
      step();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
      check_const("same_reg", 8'h81, 8'h81, 1'b0);

      // Reset while a write to reg6 is held
      drive(1'b1, 1'b0, 3'd6, 8'h55, 3'd6, 3'd6);
      step();
      drive(1'b1, 1'b1, 3'd6, 8'h99, 3'd6, 3'd6);
      step();
      check_const("hold6", 8'h55, 8'h55, 1'b1);
      RESET = 1'b1;
      model_clear();
      check_const("hold_rst", 8'h00, 8'h00, 1'b0);
      step();
      RESET = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd6);
      step();
      step();
      check_const("no_late_wr", 8'h00, 8'h00, 1'b0);

      // Forwarding check: reg4 holds 11, write 07 pending on this edge
      drive(1'b1, 1'b0, 3'd4, 8'h11, 3'd0, 3'd0);
      step();
      drive(1'b1, 1'b0, 3'd4, 8'h07, 3'd4, 3'd4);
      check_const("bypass", BYPASS ? 8'h07 : 8'h11, BYPASS ? 8'h07 : 8'h11, 1'b0);
      step();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4);
      check_const("after_commit", 8'h07, 8'h07, 1'b0);

      // Randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            RESET = 1'b1;
            model_clear();
            check_now("rnd_rst");
            step();
            RESET = 1'b0;
         end else begin
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                  3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom));
            check_now("rnd");
            step();
         end
      end

      // Final dump of storage
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
      step();
      for (int i = 0; i < 8; i += 2) begin
         OUT1ADDRESS = 3'(i);
         OUT2ADDRESS = 3'(i + 1);
         check_now("dump");
      end

      #2;
      total_cnt++;
      if (q.size() != 0)
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      else
         pass_cnt++;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
